// File: rtl/psum_pkg.sv
// Shared widths, mode encodings and FSM state type for the packed partial-sum drain.
// The optional ReLU clamp is enabled with the PSUM_DRAIN_RELU_EN macro (see psum_lane_select).
package psum_pkg;

    localparam int HEADROOM = 4;
    localparam int W88      = 16 + HEADROOM;
    localparam int W18      = 10 + HEADROOM;
    localparam int PACK_W   = 4 * W18;
    localparam int OUT_W    = W88;

    localparam logic MODE_88 = 1'b0;
    localparam logic MODE_18 = 1'b1;

    localparam int N88 = 2;
    localparam int N18 = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    // Index of the final lane for a given mode tag.
    function automatic logic [1:0] last_lane_of(input logic mode);
        return (mode == MODE_18) ? 2'(N18 - 1) : 2'(N88 - 1);
    endfunction

endpackage

// File: rtl/psum_lane_select.sv
// Combinational lane slice and sign extension of the held packed word.
// With PSUM_DRAIN_RELU_EN defined, negative lanes are clamped to zero.
module psum_lane_select
    import psum_pkg::*;
(
    input  logic                    [PACK_W-1:0] word,
    input  logic                                 mode,
    input  logic                    [1:0]        lane,
    output logic signed             [OUT_W-1:0]  value
);

    logic signed [OUT_W-1:0] raw;

    function automatic logic signed [OUT_W-1:0] sext18(input logic [W18-1:0] v);
        return {{(OUT_W - W18){v[W18-1]}}, v};
    endfunction

    // Wide lanes already match the output width, so this is a pure reinterpretation.
    function automatic logic signed [OUT_W-1:0] sext88(input logic [W88-1:0] v);
        return signed'(v);
    endfunction

`ifdef PSUM_DRAIN_RELU_EN
    function automatic logic signed [OUT_W-1:0] relu(input logic signed [OUT_W-1:0] v);
        return v[OUT_W-1] ? '0 : v;
    endfunction
`endif

    always_comb begin
        raw = '0;
        if (mode == MODE_18) begin
            raw = sext18(word[W18*lane +: W18]);
        end else begin
            raw = sext88(word[W88*lane[0] +: W88]);
        end
`ifdef PSUM_DRAIN_RELU_EN
        value = relu(raw);
`else
        value = raw;
`endif
    end

endmodule

// File: rtl/psum_lane_drain.sv
// Captures one packed accumulator word and streams its lanes one per beat, pulsing
// acc_clr on capture. Optional ReLU clamp via PSUM_DRAIN_RELU_EN.
module psum_lane_drain
    import psum_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [PACK_W-1:0]       in_data,
    input  logic                    in_mode,
    output logic                    acc_clr,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [OUT_W-1:0] out_data,
    output logic [1:0]              out_lane,
    output logic                    out_last,
    output logic                    busy
);

    state_t            state_p0, state_nx;
    logic [PACK_W-1:0] word_p0, word_nx;
    logic              mode_p0, mode_nx;
    logic [1:0]        lane_p0, lane_nx;
    logic              acc_clr_p0;
    logic              capture;

    assign out_valid = (state_p0 == DRAIN);
    assign busy      = (state_p0 == DRAIN);
    assign out_last  = (state_p0 == DRAIN) && (lane_p0 == last_lane_of(mode_p0));
    // A new word may be taken in the same cycle the last beat leaves, so no bubble.
    assign in_ready  = (state_p0 == IDLE) || (out_last && out_ready);
    assign capture   = in_valid && in_ready;
    assign out_lane  = lane_p0;
    assign acc_clr   = acc_clr_p0;

    always_comb begin
        state_nx = state_p0;
        word_nx  = word_p0;
        mode_nx  = mode_p0;
        lane_nx  = lane_p0;
        case (state_p0)
            IDLE: begin
                if (capture) begin
                    state_nx = DRAIN;
                    word_nx  = in_data;
                    mode_nx  = in_mode;
                    lane_nx  = 2'd0;
                end
            end
            DRAIN: begin
                if (out_ready) begin
                    if (!out_last) begin
                        lane_nx = lane_p0 + 2'd1;
                    end else if (capture) begin
                        word_nx = in_data;
                        mode_nx = in_mode;
                        lane_nx = 2'd0;
                    end else begin
                        state_nx = IDLE;
                        lane_nx  = 2'd0;
                    end
                end
            end
            default: begin
                state_nx = IDLE;
                lane_nx  = 2'd0;
            end
        endcase
    end

    // Stage p0: held word, mode, lane counter and clear pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            state_p0   <= IDLE;
            word_p0    <= '0;
            mode_p0    <= MODE_88;
            lane_p0    <= 2'd0;
            acc_clr_p0 <= 1'b0;
        end else begin
            state_p0   <= state_nx;
            word_p0    <= word_nx;
            mode_p0    <= mode_nx;
            lane_p0    <= lane_nx;
            acc_clr_p0 <= capture;
        end
    end

    psum_lane_select u_lane_select (
        .word  (word_p0),
        .mode  (mode_p0),
        .lane  (lane_p0),
        .value (out_data)
    );

endmodule

// File: tb/tb_psum_lane_drain.sv
// Scoreboard bench for psum_lane_drain: expected beats are queued at stimulus time
// and popped as accepted beats appear on the output stream.
module tb_psum_lane_drain;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [55:0] in_data;
    logic        in_mode;
    logic        acc_clr;
    logic        out_valid;
    logic        out_ready;
    logic [19:0] out_data;
    logic [1:0]  out_lane;
    logic        out_last;
    logic        busy;

    typedef struct packed {
        logic [19:0] d;
        logic [1:0]  l;
        logic        last;
    } beat_t;

    beat_t sb[$];
    beat_t exp_b;
    int    errors = 0;
    int    checks = 0;

    always #5 clk = ~clk;

    psum_lane_drain dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_mode   (in_mode),
        .acc_clr   (acc_clr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_lane  (out_lane),
        .out_last  (out_last),
        .busy      (busy)
    );

    function automatic logic [19:0] rl(input logic [19:0] v);
`ifdef PSUM_DRAIN_RELU_EN
        return v[19] ? 20'h0 : v;
`else
        return v;
`endif
    endfunction

    function automatic beat_t mk(input logic [19:0] d, input logic [1:0] l, input logic last);
        beat_t b;
        b.d = rl(d);
        b.l = l;
        b.last = last;
        return b;
    endfunction

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; in_data = '0; in_mode = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({out_valid, acc_clr, busy, in_ready, out_data, out_lane, out_last} !== {4'b0001, 20'h0, 2'd0, 1'b0}) begin
            errors++;
            $display("FAIL reset_state: valid=%b clr=%b busy=%b in_ready=%b data=%h lane=%0d last=%b, expected 0 0 0 1 00000 0 0",
                     out_valid, acc_clr, busy, in_ready, out_data, out_lane, out_last);
        end
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_mode0();
        int clr = 0;
        int bsy = 0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b1; in_data = {16'h1234, 20'h00005, 20'hFFFFE}; in_mode = 1'b0;
        sb.push_back(mk(20'hFFFFE, 2'd0, 1'b0));
        sb.push_back(mk(20'h00005, 2'd1, 1'b1));
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL idle_in_ready: got %b expected 1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (acc_clr) clr++;
            if (busy) bsy++;
            if (out_valid && out_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++; $display("FAIL mode0_extra_beat: data=%h lane=%0d", out_data, out_lane);
                end else begin
                    exp_b = sb.pop_front();
                    if ({out_data, out_lane, out_last} !== exp_b) begin
                        errors++;
                        $display("FAIL mode0_beat: data=%h lane=%0d last=%b expected data=%h lane=%0d last=%b",
                                 out_data, out_lane, out_last, exp_b.d, exp_b.l, exp_b.last);
                    end
                end
            end
        end
        checks++;
        if (sb.size() != 0) begin
            errors++; $display("FAIL mode0_missing: %0d beats left, expected 0", sb.size()); sb.delete();
        end
        checks++;
        if (clr != 1) begin errors++; $display("FAIL mode0_acc_clr: pulses=%0d expected 1", clr); end
        checks++;
        if (bsy != 2) begin errors++; $display("FAIL mode0_busy: cycles=%0d expected 2", bsy); end
    endtask

    task automatic test_mode1();
        int clr = 0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b1; in_data = {14'h2000, 14'h1FFF, 14'h3FFF, 14'h0001}; in_mode = 1'b1;
        sb.push_back(mk(20'h00001, 2'd0, 1'b0));
        sb.push_back(mk(20'hFFFFF, 2'd1, 1'b0));
        sb.push_back(mk(20'h01FFF, 2'd2, 1'b0));
        sb.push_back(mk(20'hFE000, 2'd3, 1'b1));
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_mode = 1'b0;
        in_data = '0;
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            if (acc_clr) clr++;
            if (out_valid && out_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++; $display("FAIL mode1_extra_beat: data=%h lane=%0d", out_data, out_lane);
                end else begin
                    exp_b = sb.pop_front();
                    if ({out_data, out_lane, out_last} !== exp_b) begin
                        errors++;
                        $display("FAIL mode1_beat: data=%h lane=%0d last=%b expected data=%h lane=%0d last=%b",
                                 out_data, out_lane, out_last, exp_b.d, exp_b.l, exp_b.last);
                    end
                end
            end
        end
        checks++;
        if (sb.size() != 0) begin
            errors++; $display("FAIL mode1_missing: %0d beats left, expected 0", sb.size()); sb.delete();
        end
        checks++;
        if (clr != 1) begin errors++; $display("FAIL mode1_acc_clr: pulses=%0d expected 1", clr); end
    endtask

    task automatic test_stall();
        logic        pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        logic        prev_stall = 1'b0;
        logic [22:0] prev = '0;
        int          beats = 0;
        @(posedge clk); #1;
        in_valid = 1'b1; in_data = {14'h0123, 14'h3F00, 14'h0ABC, 14'h2001}; in_mode = 1'b1;
        sb.push_back(mk(20'hFE001, 2'd0, 1'b0));
        sb.push_back(mk(20'h00ABC, 2'd1, 1'b0));
        sb.push_back(mk(20'hFFF00, 2'd2, 1'b0));
        sb.push_back(mk(20'h00123, 2'd3, 1'b1));
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int c = 0; c < 16; c++) begin
            out_ready = pat[c % 4];
            @(negedge clk);
            if (prev_stall) begin
                checks++;
                if (!out_valid || {out_data, out_lane, out_last} !== prev) begin
                    errors++;
                    $display("FAIL stall_stable: valid=%b data=%h lane=%0d last=%b expected held %h",
                             out_valid, out_data, out_lane, out_last, prev);
                end
            end
            prev_stall = out_valid && !out_ready;
            prev = {out_data, out_lane, out_last};
            if (out_valid && out_ready) begin
                beats++;
                checks++;
                if (sb.size() == 0) begin
                    errors++; $display("FAIL stall_extra_beat: data=%h lane=%0d", out_data, out_lane);
                end else begin
                    exp_b = sb.pop_front();
                    if ({out_data, out_lane, out_last} !== exp_b) begin
                        errors++;
                        $display("FAIL stall_beat: data=%h lane=%0d last=%b expected data=%h lane=%0d last=%b",
                                 out_data, out_lane, out_last, exp_b.d, exp_b.l, exp_b.last);
                    end
                end
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        checks++;
        if (beats != 4 || sb.size() != 0) begin
            errors++; $display("FAIL stall_beat_count: beats=%0d left=%0d expected 4 and 0", beats, sb.size());
            sb.delete();
        end
    endtask

    task automatic test_back_to_back();
        int  clr = 0;
        int  vcnt = 0;
        int  first = -1;
        int  last_i = -1;
        int  takes = 0;
        logic took;
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b1; in_data = {16'h0000, 20'hFFFF9, 20'h00003}; in_mode = 1'b0;
        sb.push_back(mk(20'h00003, 2'd0, 1'b0));
        sb.push_back(mk(20'hFFFF9, 2'd1, 1'b1));
        sb.push_back(mk(20'h00064, 2'd0, 1'b0));
        sb.push_back(mk(20'hFFFFF, 2'd1, 1'b1));
        @(posedge clk); #1;
        in_data = {16'hABCD, 20'hFFFFF, 20'h00064};
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            took = in_valid && in_ready;
            if (took) takes++;
            if (c == 0) begin
                checks++;
                if (in_ready !== 1'b0) begin
                    errors++; $display("FAIL b2b_hold_off: in_ready=%b mid-drain expected 0", in_ready);
                end
            end
            if (acc_clr) clr++;
            if (out_valid) begin
                vcnt++;
                if (first < 0) first = c;
                last_i = c;
            end
            if (out_valid && out_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++; $display("FAIL b2b_extra_beat: data=%h lane=%0d", out_data, out_lane);
                end else begin
                    exp_b = sb.pop_front();
                    if ({out_data, out_lane, out_last} !== exp_b) begin
                        errors++;
                        $display("FAIL b2b_beat: data=%h lane=%0d last=%b expected data=%h lane=%0d last=%b",
                                 out_data, out_lane, out_last, exp_b.d, exp_b.l, exp_b.last);
                    end
                end
            end
            @(posedge clk); #1;
            if (took) in_valid = 1'b0;
        end
        in_valid = 1'b0;
        checks++;
        if (vcnt != 4 || first != 0 || last_i != 3 || takes != 1) begin
            errors++;
            $display("FAIL b2b_no_bubble: valid_cycles=%0d first=%0d last=%0d captures=%0d expected 4 0 3 1",
                     vcnt, first, last_i, takes);
        end
        checks++;
        if (clr != 2) begin errors++; $display("FAIL b2b_acc_clr: pulses=%0d expected 2", clr); end
        checks++;
        if (sb.size() != 0) begin
            errors++; $display("FAIL b2b_missing: %0d beats left, expected 0", sb.size()); sb.delete();
        end
    endtask

    task automatic test_reset_mid();
        int vcnt = 0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b1; in_data = {14'h0008, 14'h0007, 14'h0006, 14'h0005}; in_mode = 1'b1;
        sb.push_back(mk(20'h00005, 2'd0, 1'b0));
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        exp_b = sb.pop_front();
        if (!out_valid || {out_data, out_lane, out_last} !== exp_b) begin
            errors++;
            $display("FAIL rst_mid_first: valid=%b data=%h lane=%0d last=%b expected data=%h lane=%0d last=%b",
                     out_valid, out_data, out_lane, out_last, exp_b.d, exp_b.l, exp_b.last);
        end
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({out_valid, busy, in_ready, acc_clr} !== 4'b0010) begin
            errors++;
            $display("FAIL rst_mid_state: valid=%b busy=%b in_ready=%b clr=%b expected 0 0 1 0",
                     out_valid, busy, in_ready, acc_clr);
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (out_valid) vcnt++;
        end
        checks++;
        if (vcnt != 0) begin errors++; $display("FAIL rst_mid_no_beats: valid_cycles=%0d expected 0", vcnt); end
        @(posedge clk); #1;
        in_valid = 1'b1; in_data = {16'h0, 20'h00016, 20'h0000B}; in_mode = 1'b0;
        sb.push_back(mk(20'h0000B, 2'd0, 1'b0));
        sb.push_back(mk(20'h00016, 2'd1, 1'b1));
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (out_valid && out_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++; $display("FAIL rst_after_extra_beat: data=%h lane=%0d", out_data, out_lane);
                end else begin
                    exp_b = sb.pop_front();
                    if ({out_data, out_lane, out_last} !== exp_b) begin
                        errors++;
                        $display("FAIL rst_after_beat: data=%h lane=%0d last=%b expected data=%h lane=%0d last=%b",
                                 out_data, out_lane, out_last, exp_b.d, exp_b.l, exp_b.last);
                    end
                end
            end
        end
        checks++;
        if (sb.size() != 0) begin
            errors++; $display("FAIL rst_after_missing: %0d beats left, expected 0", sb.size()); sb.delete();
        end
    endtask

    initial begin
        test_reset();
        test_mode0();
        test_mode1();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/psum_lane_drain.md
Name: psum_lane_drain

Overview:
- Reader side of the packed-SIMD MAC accumulator word.
- Captures one packed partial-sum word plus its mode tag, then serialises the lanes one per beat on a valid/ready stream, each lane sign-extended to a common width.
- Issues a one-cycle clear pulse so the upstream accumulator restarts while draining proceeds.
- Sits between the PE MAC array and the output requant/writeback path.

Parameters:
- HEADROOM, 4, accumulator guard bits per lane
- W88, 16+HEADROOM (20), lane width in mode 0 (8x8)
- W18, 10+HEADROOM (14), lane width in mode 1 (1x8 packed)
- PACK_W, 4*W18 (56), packed input word width
- OUT_W, W88 (20), output lane width after sign extension

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  packed word available
- in_ready  out  1  block can capture a word this cycle
- in_data  in  PACK_W  packed accumulator word
- in_mode  in  1  0 = two W88 lanes; 1 = four W18 lanes
- acc_clr  out  1  one-cycle pulse on capture, to the accumulator clear
- out_valid  out  1  lane beat valid
- out_ready  in  1  downstream accepts beat
- out_data  out  OUT_W  sign-extended lane value
- out_lane  out  2  lane index of current beat
- out_last  out  1  final lane of the captured word
- busy  out  1  high while in DRAIN

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, on port reset.
- Reset values: state = IDLE, out_valid = 0, acc_clr = 0, busy = 0, lane_cnt = 0, out_data = 0, out_lane = 0, out_last = 0. Holding registers for the word and mode are cleared.
- Lane layout, mode 0:
  - lane0 = in_data[19:0], lane1 = in_data[39:20].
  - Bits [55:40] are ignored.
  - Lane count N = 2.
- Lane layout, mode 1:
  - lane k = in_data[14k +: 14], k = 0..3.
  - Lane count N = 4.
- Each lane is sign-extended from its MSB to OUT_W. No carry or borrow between lanes.
- FSM, IDLE:
  - in_ready = 1, out_valid = 0.
  - On in_valid: latch in_data and in_mode, set lane_cnt = 0, pulse acc_clr the next cycle, go to DRAIN.
- FSM, DRAIN:
  - out_valid = 1, busy = 1.
  - out_data and out_lane are driven from registered lane_cnt.
  - out_last = (lane_cnt == N-1).
  - On out_ready with out_last = 0: lane_cnt += 1.
  - On out_ready with out_last = 1: go to IDLE, unless back-to-back applies.
- Back-to-back:
  - in_ready = IDLE | (DRAIN & out_last & out_ready). This is a combinational path from out_ready.
  - If a capture coincides with acceptance of the last beat: load the new word, lane_cnt = 0, stay in DRAIN, pulse acc_clr.
  - No bubble between words.
- Stall: out_valid held high with out_data, out_lane and out_last stable while out_ready = 0. Stream-protocol rule.
- Latency: first beat valid 1 cycle after the capture handshake. A word drains in N cycles under continuous out_ready.
- Mode is latched at capture; in_mode changes during DRAIN have no effect.
- in_valid during DRAIN before the last beat is not accepted (in_ready = 0). Upstream holds it.
- Reset mid-drain: abandons the word, returns to IDLE, no further beats, acc_clr = 0.
- lane_cnt is 2 bits. It never exceeds N-1 and does not wrap in mode 0.

Optional Feature:
- Macro: PSUM_DRAIN_RELU_EN.
- Defined: out_data is forced to 0 when the sign-extended lane is negative; non-negative lanes pass unchanged. This applies to both modes and adds no latency.
- Undefined: raw signed lanes are output.

Decomposition:
- Shared package psum_pkg:
  - HEADROOM, W88, W18, PACK_W, OUT_W.
  - Mode encoding constants MODE_88 = 0 and MODE_18 = 1.
  - Lane count constants N88 = 2 and N18 = 4.
  - FSM state typedef {IDLE, DRAIN}.
- One natural sub-module: psum_lane_select.
  - Combinational lane slice plus sign-extension (plus ReLU under the macro).
  - Inputs: held word, mode, lane_cnt. Output: OUT_W value.

Test Plan:
1. Mode 0, lane0 = 20'hFFFFE (-2), lane1 = 20'h00005, out_ready = 1 -> beats -2 (lane 0) then 5 (lane 0x1, last); acc_clr pulses once; busy high for 2 cycles.
2. Mode 1, lanes {14'h2000, 14'h1FFF, 14'h3FFF, 14'h0001} for k = 3..0 -> beats 1, -1, 8191, -8192, sign-extended to 20 bits; out_last only on lane 3.
3. Mode 1 with out_ready toggling 1,0,0,1,... -> out_data, out_lane and out_last stable during stalls; exactly 4 beats total; no duplicate or skipped lane.
4. Back-to-back: second mode-0 word presented with in_valid held through the first drain -> captured on the cycle the first word's last beat is accepted; zero idle cycles; second acc_clr pulse.
5. Assert reset after beat 1 of a mode-1 word -> next cycle out_valid = 0, state IDLE, in_ready = 1; a following word drains from lane 0.
6. With PSUM_DRAIN_RELU_EN defined, scenario 2 input -> beats 1, 0, 8191, 0.
